// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - parallel word handshake between a producer and uart_tx
interface uart_tx_if #(
  parameter int DATA_BITS = 2
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-buffered UART transmitter, start/data(LSB first)/stop framing
module uart_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_tx_if.slave                      up,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_TICK = CLK_FREQ / BAUD_RATE;
  localparam int CW        = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;
  localparam int BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int NW        = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop;
  logic                 launch_q;

  state_t               state, state_next;
  logic                 tx_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [BW-1:0]        bit_cnt, bit_cnt_next;
  logic [CW-1:0]        baud_cnt, baud_cnt_next;
  logic                 bit_end;

  // Room is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign up.ready = (fifo_count < NW'(FIFO_DEPTH));
  assign push     = up.valid && up.ready;
  assign busy     = (state != IDLE);
  assign bit_end  = (baud_cnt == CW'(BAUD_TICK - 1));

  // Queue storage; stale contents are harmless because the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= up.data;
  end

  // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Transmitter state; the idle launch waits one cycle after the queue turns non-empty,
  // which gives the two-edge accept-to-start-bit latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      launch_q <= 1'b0;
    end else begin
      state    <= state_next;
      tx       <= tx_next;
      shift    <= shift_next;
      bit_cnt  <= bit_cnt_next;
      baud_cnt <= baud_cnt_next;
      launch_q <= (state == IDLE) && (fifo_count != '0);
    end
  end

  // Next-state, pop and line-level decisions at each bit boundary.
  always_comb begin
    state_next    = state;
    tx_next       = tx;
    shift_next    = shift;
    bit_cnt_next  = bit_cnt;
    baud_cnt_next = bit_end ? '0 : baud_cnt + 1'b1;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_next = '0;
        tx_next       = 1'b1;
        if (launch_q && fifo_count != '0) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          tx_next      = shift[0];
          bit_cnt_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            shift_next   = shift >> 1;
            bit_cnt_next = bit_cnt + 1'b1;
            tx_next      = shift_next[0];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (fifo_count != '0) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx with a serial receiver model
module tb_uart_tx;
  localparam int DB = 2;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx, busy;
  logic [2:0]  fifo_count;

  uart_tx_if #(.DATA_BITS(DB)) bus ();

  uart_tx #(
    .CLK_FREQ(80), .BAUD_RATE(10), .DATA_BITS(DB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .up(bus), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Receiver model: detect start, sample each bit mid-way, collect words.
  logic [DB-1:0] rx_words[$];
  int            rx_starts[$];
  bit            rx_active = 0;
  int            rx_phase;
  int            rx_k;
  logic [DB-1:0] rx_sh;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      rx_active = 0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1;
        rx_phase  = 0;
        rx_starts.push_back(cyc);
      end
    end else begin
      rx_phase++;
      if (rx_phase % 8 == 4) begin
        rx_k = rx_phase / 8;
        if (rx_k == 0) check("rx_start_bit", tx, 1'b0);
        else if (rx_k <= DB) rx_sh[rx_k-1] = tx;
        else begin
          check("rx_stop_bit", tx, 1'b1);
          rx_words.push_back(rx_sh);
        end
      end
      if (rx_phase == 8 * (DB + 2) - 1) rx_active = 0;
    end
  end

  int push_cyc;

  task automatic push(input logic [DB-1:0] d);
    @(negedge clk);
    bus.data  = d;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    push_cyc  = cyc;
  endtask

  task automatic capture(output int n, output logic [127:0] v);
    int w;
    w = 0;
    n = 0;
    v = '0;
    while (!busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!busy) begin
      check("capture_busy_timeout", busy, 1'b1);
      return;
    end
    while (busy && n < 128) begin
      v[n] = tx;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || fifo_count != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy || fifo_count != 0) check("idle_timeout", 1'b1, 1'b0);
  endtask

  int            n;
  logic [127:0]  v;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] nd;
  bit            saw_full;
  int            bad;
  logic [DB-1:0] lb[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    bus.data  = '0;
    bus.valid = 1'b0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", bus.ready, 1'b1);
    check("rst_count", fifo_count, 3'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word 2'b10
    rx_words.delete(); rx_starts.delete();
    push(2'b10);
    check("sw_count_after_push", fifo_count, 3'd1);
    check("sw_tx_edge_n", tx, 1'b1);
    @(negedge clk);
    check("sw_tx_edge_n1", tx, 1'b1);
    check("sw_busy_edge_n1", busy, 1'b0);
    @(negedge clk);
    check("sw_tx_edge_n2", tx, 1'b0);
    check("sw_busy_edge_n2", busy, 1'b1);
    check("sw_count_popped", fifo_count, 3'd0);
    capture(n, v);
    check("sw_busy_cycles", n, 32);
    check("sw_wave", v, 128'hFFFF0000);
    check("sw_tx_after", tx, 1'b1);
    check("sw_rx_n", rx_words.size(), 1);
    check("sw_rx_word", rx_words.size() > 0 ? rx_words[0] : 2'bxx, 2'b10);
    check("sw_latency", rx_starts.size() > 0 ? rx_starts[0] : -1, push_cyc + 2);

    // Back-to-back 01, 11, 00
    repeat (4) @(negedge clk);
    rx_words.delete(); rx_starts.delete();
    bus.valid = 1'b1; bus.data = 2'b01;
    @(negedge clk); bus.data = 2'b11;
    @(negedge clk); bus.data = 2'b00;
    @(negedge clk); bus.valid = 1'b0;
    check("b2b_count", fifo_count, 3'd2);
    check("b2b_busy", busy, 1'b1);
    capture(n, v);
    check("b2b_busy_cycles", n, 96);
    check("b2b_wave", v, 128'hFF000000_FFFFFF00_FF00FF00);
    check("b2b_rx_n", rx_words.size(), 3);
    if (rx_words.size() == 3) begin
      check("b2b_w0", rx_words[0], 2'b01);
      check("b2b_w1", rx_words[1], 2'b11);
      check("b2b_w2", rx_words[2], 2'b00);
      check("b2b_gap01", rx_starts[1] - rx_starts[0], 32);
      check("b2b_gap12", rx_starts[2] - rx_starts[1], 32);
    end

    // Full FIFO: valid held with incrementing data
    repeat (4) @(negedge clk);
    rx_words.delete(); exp_q.delete();
    nd = '0; saw_full = 0;
    bus.valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      bus.data = nd;
      if (bus.ready) begin
        exp_q.push_back(nd);
        nd = nd + 1'b1;
      end
      if (fifo_count == 3'd4 && !saw_full) begin
        saw_full = 1;
        check("full_ready_low", bus.ready, 1'b0);
      end
      @(negedge clk);
    end
    bus.valid = 1'b0;
    check("full_reached", saw_full, 1'b1);
    check("full_accepted", exp_q.size(), 7);
    wait_idle(600);
    check("full_rx_n", rx_words.size(), 7);
    bad = 0;
    for (int i = 0; i < 7; i++)
      if (i >= rx_words.size() || rx_words[i] !== 2'(i)) bad++;
    check("full_order", bad, 0);

    // Reset during bit1 of a frame with a word queued behind it
    repeat (4) @(negedge clk);
    push(2'b01);
    push(2'b10);
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    repeat (19) @(negedge clk);
    check("rm_bit1_low", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rm_tx", tx, 1'b1);
    check("rm_busy", busy, 1'b0);
    check("rm_ready", bus.ready, 1'b1);
    check("rm_count", fifo_count, 3'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rx_words.delete();
    push(2'b11);
    capture(n, v);
    check("rm_busy_cycles", n, 32);
    check("rm_wave", v, 128'hFFFFFF00);
    repeat (60) @(negedge clk);
    check("rm_idle_busy", busy, 1'b0);
    check("rm_idle_count", fifo_count, 3'd0);
    check("rm_rx_n", rx_words.size(), 1);
    check("rm_rx_word", rx_words.size() > 0 ? rx_words[0] : 2'bxx, 2'b11);

    // Loopback of all four words
    rx_words.delete();
    lb[0] = 2'b00; lb[1] = 2'b01; lb[2] = 2'b10; lb[3] = 2'b11;
    for (int i = 0; i < 4; i++) push(lb[i]);
    wait_idle(800);
    check("lb_rx_n", rx_words.size(), 4);
    if (rx_words.size() == 4)
      for (int i = 0; i < 4; i++) check($sformatf("lb_w%0d", i), rx_words[i], lb[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
